// File: rtl/display_scan_ctrl.sv
// Scan controller for an N-digit common-anode 7-segment display sharing one decoder.
// A loaded value is staged and moved to the displayed copy only at frame boundaries.
module display_scan_ctrl #(
   parameter int N_DIG = 4,
   parameter int DIV   = 1000,
   parameter int BLANK = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4*N_DIG-1:0] dato_i,
   input  logic               cargar_i,
   input  logic               supr_ceros_i,
   input  logic               habilitar_i,
   output logic [3:0]         palabra_o,
   output logic [N_DIG-1:0]   an_o,
   output logic               pendiente_o,
   output logic               fin_cuadro_o
);

   localparam int CW = $clog2(DIV);
   localparam int IW = $clog2(N_DIG);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

   typedef enum logic {INACTIVO, ESCANEO} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   // Bit 4*N_DIG holds the suppression request travelling with the value.
   logic [4*N_DIG:0]   staged_q, staged_d;
   logic [4*N_DIG:0]   shadow_q, shadow_d;
   logic               pend_q, pend_d;
   logic [N_DIG-1:0]   an_q, an_d;
   logic [3:0]         palabra_q, palabra_d;
   logic               fin_q, fin_d;
   logic               boundary;

   logic [3:0]         dig [N_DIG];
   logic               lead_z [N_DIG];
   logic               supp [N_DIG];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      staged_d = staged_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      boundary = (state_q == INACTIVO) || (cnt_q == CNT_LAST && idx_q == IDX_LAST);

      if (cargar_i) begin
         staged_d = {supr_ceros_i, dato_i};
         if (boundary) begin
            shadow_d = {supr_ceros_i, dato_i};
            pend_d   = 1'b0;
         end else begin
            pend_d   = 1'b1;
         end
      end else if (boundary && pend_q) begin
         shadow_d = staged_q;
         pend_d   = 1'b0;
      end

      case (state_q)
         INACTIVO: begin
            cnt_d = '0;
            idx_d = '0;
            if (habilitar_i) state_d = ESCANEO;
         end
         ESCANEO: begin
            if (!habilitar_i) begin
               state_d = INACTIVO;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = INACTIVO;
      endcase
   end

   // Digit k is a leading zero when it and every digit above it are zero.
   generate
      for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
         assign dig[gi] = shadow_d[4*gi +: 4];
         if (gi == N_DIG - 1) begin : g_top
            assign lead_z[gi] = (dig[gi] == 4'h0);
         end else begin : g_low
            assign lead_z[gi] = (dig[gi] == 4'h0) && lead_z[gi+1];
         end
         if (gi == 0) begin : g_d0
            assign supp[gi] = 1'b0;
         end else begin : g_dk
            assign supp[gi] = shadow_d[4*N_DIG] && lead_z[gi];
         end
      end
   endgenerate

   // Outputs are registered from the next-cycle view so they line up with cnt_q/idx_q.
   always_comb begin
      palabra_d = dig[idx_d];
      an_d      = '1;
      fin_d     = 1'b0;
      if (state_d == ESCANEO) begin
         if (cnt_d >= BLANK_C && !supp[idx_d]) an_d[idx_d] = 1'b0;
         fin_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INACTIVO;
         cnt_q     <= '0;
         idx_q     <= '0;
         staged_q  <= '0;
         shadow_q  <= '0;
         pend_q    <= 1'b0;
         an_q      <= '1;
         palabra_q <= 4'h0;
         fin_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         staged_q  <= staged_d;
         shadow_q  <= shadow_d;
         pend_q    <= pend_d;
         an_q      <= an_d;
         palabra_q <= palabra_d;
         fin_q     <= fin_d;
      end
   end

   assign palabra_o    = palabra_q;
   assign an_o         = an_q;
   assign pendiente_o  = pend_q;
   assign fin_cuadro_o = fin_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a frame-timeline model pushes the expected
// outputs for every clock edge, which are popped and compared one cycle later.
module tb_display_scan_ctrl;

   localparam int N_DIG = 4;
   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = N_DIG * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] dato = 16'h0;
   logic        cargar = 1'b0;
   logic        supr = 1'b0;
   logic        hab = 1'b0;
   logic [3:0]  palabra_o;
   logic [3:0]  an_o;
   logic        pendiente_o;
   logic        fin_cuadro_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] an;
      logic [3:0] pal;
      logic       fin;
      logic       pend;
   } exp_t;
   exp_t exp_q[$];

   // Model: m_t is the position inside the frame of the cycle currently shown.
   bit          m_scan = 1'b0;
   int          m_t = 0;
   logic [16:0] m_staged = '0;
   logic [16:0] m_shadow = '0;
   bit          m_pend = 1'b0;

   display_scan_ctrl #(.N_DIG(N_DIG), .DIV(DIV), .BLANK(BLANK)) dut (
      .clk          (clk),
      .rst          (rst),
      .dato_i       (dato),
      .cargar_i     (cargar),
      .supr_ceros_i (supr),
      .habilitar_i  (hab),
      .palabra_o    (palabra_o),
      .an_o         (an_o),
      .pendiente_o  (pendiente_o),
      .fin_cuadro_o (fin_cuadro_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit suppressed(input int k);
      logic [15:0] v;
      v = m_shadow[15:0];
      return m_shadow[16] && (k >= 1) && ((v >> (4 * k)) == 16'h0);
   endfunction

   task automatic step();
      exp_t e;
      exp_t g;
      bit   bnd;
      int   idx;
      int   cnt;
      if (rst) begin
         m_scan = 1'b0; m_t = 0; m_staged = '0; m_shadow = '0; m_pend = 1'b0;
      end else begin
         bnd = !m_scan || (m_t == FRAME - 1);
         if (cargar) begin
            m_staged = {supr, dato};
            if (bnd) begin
               m_shadow = {supr, dato};
               m_pend   = 1'b0;
            end else begin
               m_pend   = 1'b1;
            end
         end else if (bnd && m_pend) begin
            m_shadow = m_staged;
            m_pend   = 1'b0;
         end
         if (!m_scan) begin
            if (hab) begin m_scan = 1'b1; m_t = 0; end
         end else if (!hab) begin
            m_scan = 1'b0; m_t = 0;
         end else begin
            m_t = (m_t + 1) % FRAME;
         end
      end
      idx   = m_scan ? m_t / DIV : 0;
      cnt   = m_t % DIV;
      e.pal = m_shadow[idx*4 +: 4];
      e.an  = 4'hF;
      if (m_scan && cnt >= BLANK && !suppressed(idx)) e.an[idx] = 1'b0;
      e.fin  = m_scan && (m_t == FRAME - 1);
      e.pend = m_pend;
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      g = exp_q.pop_front();
      chk("an_o", 32'(an_o), 32'(g.an));
      chk("palabra_o", 32'(palabra_o), 32'(g.pal));
      chk("fin_cuadro_o", 32'(fin_cuadro_o), 32'(g.fin));
      chk("pendiente_o", 32'(pendiente_o), 32'(g.pend));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_t(input int target);
      bit hit = 1'b0;
      for (int i = 0; i < 4 * FRAME && !hit; i++) begin
         if (m_scan && m_t == target) hit = 1'b1;
         else step();
      end
      chk("wait_frame_pos", 32'(hit), 32'd1);
   endtask

   task automatic load(input logic [15:0] v, input logic s);
      dato   = v;
      supr   = s;
      cargar = 1'b1;
      $display("load value=%h supr=%0b frame_pos=%0d scanning=%0b", v, s, m_t, m_scan);
      step();
      cargar = 1'b0;
   endtask

   initial begin
      // Reset state
      run(3);
      chk("reset_an", 32'(an_o), 32'hF);
      chk("reset_pal", 32'(palabra_o), 32'h0);
      rst = 1'b0;
      $display("txn reset released");

      // Scan with no value loaded
      hab = 1'b1;
      run(FRAME + 8);
      $display("txn blank-value frame done");

      // Load while idle, then scan it
      hab = 1'b0;
      run(3);
      load(16'h1A3F, 1'b0);
      chk("idle_load_pal", 32'(palabra_o), 32'hF);
      run(2);
      hab = 1'b1;
      run(FRAME + 4);

      // Mid-frame load waits for the boundary
      wait_t(DIV + 2);
      load(16'h0042, 1'b0);
      run(2 * FRAME);

      // Leading-zero suppression
      load(16'h0042, 1'b1);
      run(2 * FRAME + 3);
      load(16'h0000, 1'b1);
      run(2 * FRAME + 3);

      // Two loads in one frame, the second on the frame's last cycle
      wait_t(5);
      load(16'h1111, 1'b0);
      wait_t(FRAME - 1);
      load(16'h2222, 1'b0);
      chk("coincide_pend", 32'(pendiente_o), 32'h0);
      run(FRAME + 8);

      // Reset during slot 2 with a load pending
      wait_t(2 * DIV + 1);
      load(16'h5555, 1'b0);
      rst = 1'b1;
      $display("txn reset mid-frame");
      step();
      rst = 1'b0;
      chk("midrst_an", 32'(an_o), 32'hF);
      chk("midrst_pend", 32'(pendiente_o), 32'h0);
      run(20);

      // Drop enable mid-slot, then resume from digit 0
      wait_t(DIV + 5);
      hab = 1'b0;
      $display("txn disable mid-slot");
      step();
      chk("disable_an", 32'(an_o), 32'hF);
      step();
      hab = 1'b1;
      $display("txn re-enable");
      run(FRAME + 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
